sr_latch_bank_ctrl: RTL and testbench
=====================================

Name: sr_latch_bank_ctrl

Overview:
Sequencer for a bank of N CMOS NOR set/reset latches built at transistor level. Accepts single write requests (set or clear one latch), drives that latch's S or R input with a timed pulse and waits a settle interval. It then checks the latch's Q/_Q feedback and retries or flags an error. After reset it clears the whole bank before accepting requests. It sits between the register-style host logic and the latch array, and guarantees S and R are never asserted together.

Parameters:
N, 6, number of latches in the bank
IDX_W, 3, width of req_idx; 2**IDX_W >= N
PULSE_W, 4, S/R pulse width in clock cycles; must be >= 1
SETTLE_W, 3, quiet cycles after the pulse before checking; must be >= 2 to cover the feedback synchroniser
MAX_RETRY, 2, re-pulses allowed after a failed check
CNT_W, 4, width of the internal timing counter; must hold max(PULSE_W, SETTLE_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_idx  in  IDX_W  target latch
req_val  in  1  1 = set (Q=1), 0 = clear (Q=0)
resp_valid  out  1  one-cycle completion pulse
resp_ok  out  1  qualified by resp_valid; 1 = latch verified
s_out  out  N  S inputs of the latches
r_out  out  N  R inputs of the latches
q_in  in  N  Q feedback from the latches (asynchronous)
qn_in  in  N  _Q feedback from the latches (asynchronous)
init_done  out  1  bank has been cleared since reset
err_sticky  out  1  a verify failure occurred
err_clr  in  1  clears err_sticky

Behaviour:
- Reset (async assert, rst_n=0): s_out=0, r_out=0, req_ready=0, resp_valid=0, resp_ok=0, init_done=0, err_sticky=0, counters=0, state=INIT_DRIVE. Reset mid-operation aborts the pulse immediately; the held request is discarded with no response.
- q_in and qn_in pass through a 2-flop synchroniser; all checks use the synchronised values.
- Feedback check passes iff q==val and qn==~val for the target bit.
- States:
  - INIT_DRIVE: r_out all ones for PULSE_W cycles, then INIT_SETTLE.
  - INIT_SETTLE: all outputs 0 for SETTLE_W cycles, then INIT_CHECK.
  - INIT_CHECK (1 cycle): every latch must read Q=0, _Q=1; on any failure set err_sticky. Then init_done=1 (stays 1 until reset) and go to IDLE. INIT issues no retries and no resp_valid.
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches idx and val.
    - idx >= N: next cycle resp_valid=1, resp_ok=0; no pulse; err_sticky unchanged; stay IDLE.
    - Otherwise go to DRIVE and clear the retry count.
  - DRIVE: exactly one bit of s_out (val=1) or r_out (val=0) is high, for exactly PULSE_W cycles beginning the cycle after the handshake. Then SETTLE.
  - SETTLE: s_out=r_out=0 for SETTLE_W cycles, then CHECK.
  - CHECK (1 cycle):
    - pass: RESP, resp_ok=1.
    - fail with retry < MAX_RETRY: increment retry, back to DRIVE.
    - fail with retry == MAX_RETRY: RESP, resp_ok=0, set err_sticky.
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Latency, handshake edge to resp_valid: (1+retries)×(PULSE_W+SETTLE_W+1)+1 cycles. Defaults give 9 cycles with no retry and 25 with two retries.
- Invariants:
  - s_out & r_out == 0 always.
  - popcount(s_out|r_out) <= 1 outside INIT_DRIVE.
  - All outputs are registered and glitch-free.
- err_clr clears err_sticky. If err_clr and a new error occur in the same cycle, the set wins.
- A pulse is issued even when the latch already holds req_val; the controller never skips a pulse.

Test Plan:
- Reset release with all latches responding -> r_out=6'b111111 for 4 cycles, then 0; init_done rises 8 cycles after the first edge; err_sticky=0.
- Request idx=2, val=1 with a latch model -> s_out=6'b000100 for 4 cycles, resp_valid=1, resp_ok=1 exactly 9 cycles after the handshake; r_out stays 0 throughout.
- Latch 5 stuck at Q=0, request idx=5, val=1 -> three 4-cycle pulses on s_out[5], resp_ok=0 at cycle 25, err_sticky=1. Then err_clr -> err_sticky=0.
- Request idx=7 (N=6) -> resp_valid with resp_ok=0 on the next cycle, no s_out/r_out activity, err_sticky unchanged.
- rst_n driven low during cycle 2 of DRIVE -> s_out=0 asynchronously, no resp_valid, and the INIT sequence reruns.
- Back-to-back requests with req_valid held high -> req_ready=0 from handshake to RESP; second handshake happens the cycle after resp_valid.

Source files
------------

// File: rtl/sr_latch_bank_ctrl.sv
// sr_latch_bank_ctrl: pulse/settle/verify sequencer for a bank of NOR S/R latches.
// Clears the whole bank after reset, then services single-latch set/clear requests.
module sr_latch_bank_ctrl #(
    parameter int N         = 6,
    parameter int IDX_W     = 3,
    parameter int PULSE_W   = 4,
    parameter int SETTLE_W  = 3,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             req_val,
    output logic             resp_valid,
    output logic             resp_ok,
    output logic [N-1:0]     s_out,
    output logic [N-1:0]     r_out,
    input  logic [N-1:0]     q_in,
    input  logic [N-1:0]     qn_in,
    output logic             init_done,
    output logic             err_sticky,
    input  logic             err_clr
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PW_C  = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] SW1_C = CNT_W'(SETTLE_W - 1);
    localparam logic [RTY_W-1:0] MR_C  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W:0]   NUM_C = (IDX_W + 1)'(N);

    typedef enum logic [2:0] {
        INIT_DRIVE,
        INIT_SETTLE,
        INIT_CHECK,
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry;
    logic [IDX_W-1:0] idx_q;
    logic             val_q;

    logic [N-1:0] q_m, q_s;
    logic [N-1:0] qn_m, qn_s;

    logic [N-1:0] sel_q;
    logic [N-1:0] sel_req;
    logic         hit_q;
    logic         hit_qn;
    logic         verify_ok;
    logic         init_ok;
    logic         handshake;
    logic         idx_ok;
    logic         retry_left;
    logic         err_set;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (i == IDX_W'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Two-flop synchroniser for the asynchronous latch feedback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_m  <= '0;
            q_s  <= '0;
            qn_m <= '0;
            qn_s <= '0;
        end else begin
            q_m  <= q_in;
            q_s  <= q_m;
            qn_m <= qn_in;
            qn_s <= qn_m;
        end
    end

    // Target selection and feedback verdicts
    always_comb begin
        sel_q      = onehot(idx_q);
        sel_req    = onehot(req_idx);
        hit_q      = |(q_s & sel_q);
        hit_qn     = |(qn_s & sel_q);
        verify_ok  = (hit_q == val_q) && (hit_qn == !val_q);
        init_ok    = (q_s == '0) && (qn_s == {N{1'b1}});
        handshake  = req_valid && req_ready;
        idx_ok     = {1'b0, req_idx} < NUM_C;
        retry_left = retry < MR_C;
        err_set    = ((state == INIT_CHECK) && !init_ok) ||
                     ((state == CHECK) && !verify_ok && !retry_left);
    end

    // Sequencer: every output is a register written only here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT_DRIVE;
            cnt        <= '0;
            retry      <= '0;
            idx_q      <= '0;
            val_q      <= 1'b0;
            s_out      <= '0;
            r_out      <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            unique case (state)
                INIT_DRIVE: begin
                    if (cnt == PW_C) begin
                        r_out <= '0;
                        cnt   <= '0;
                        state <= INIT_SETTLE;
                    end else begin
                        r_out <= '1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                INIT_SETTLE: begin
                    if (cnt == SW1_C) begin
                        cnt   <= '0;
                        state <= INIT_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_CHECK: begin
                    init_done <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                IDLE: begin
                    if (handshake) begin
                        idx_q <= req_idx;
                        val_q <= req_val;
                        if (idx_ok) begin
                            // pulse starts on the handshake edge, so count it now
                            req_ready <= 1'b0;
                            retry     <= '0;
                            cnt       <= CNT_W'(1);
                            s_out     <= req_val ? sel_req : '0;
                            r_out     <= req_val ? '0 : sel_req;
                            state     <= DRIVE;
                        end else begin
                            resp_valid <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == PW_C) begin
                        s_out <= '0;
                        r_out <= '0;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == SW1_C) begin
                        cnt   <= '0;
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (verify_ok) begin
                        resp_valid <= 1'b1;
                        resp_ok    <= 1'b1;
                        state      <= RESP;
                    end else if (retry_left) begin
                        retry <= retry + 1'b1;
                        cnt   <= CNT_W'(1);
                        s_out <= val_q ? sel_q : '0;
                        r_out <= val_q ? '0 : sel_q;
                        state <= DRIVE;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= INIT_DRIVE;
                end
            endcase
        end
    end

    // Sticky verify error; a new failure beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// tb_sr_latch_bank_ctrl: directed bench for the latch bank sequencer.
// Uses a behavioural NOR latch model with an optional stuck-at-0 on latch 5.
module tb_sr_latch_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_idx = '0;
    logic       req_val = 1'b0;
    logic       resp_valid;
    logic       resp_ok;
    logic [5:0] s_out;
    logic [5:0] r_out;
    logic [5:0] q_in;
    logic [5:0] qn_in;
    logic       init_done;
    logic       err_sticky;
    logic       err_clr = 1'b0;

    logic [5:0] lat = 6'h3f;
    logic [5:0] stuck0 = '0;

    int checks = 0;
    int fails = 0;
    int overlap = 0;

    sr_latch_bank_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_val   (req_val),
        .resp_valid(resp_valid),
        .resp_ok   (resp_ok),
        .s_out     (s_out),
        .r_out     (r_out),
        .q_in      (q_in),
        .qn_in     (qn_in),
        .init_done (init_done),
        .err_sticky(err_sticky),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Latch model: S sets, R clears, neither holds
    always @(s_out or r_out) begin
        for (int i = 0; i < 6; i++) begin
            if (s_out[i]) lat[i] = 1'b1;
            else if (r_out[i]) lat[i] = 1'b0;
        end
    end

    assign q_in  = lat & ~stuck0;
    assign qn_in = ~q_in;

    // Drive-safety monitor
    always @(negedge clk) begin
        if ((s_out & r_out) != 0) overlap++;
        if (init_done && $countones(s_out | r_out) > 1) overlap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Watch the bank clear after reset release
    task automatic run_init(output int rc, output int rbad,
                            output int done_k, output int rv);
        rc = 0;
        rbad = 0;
        done_k = 0;
        rv = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (r_out == 6'h3f) rc++;
            else if (r_out != 0) rbad++;
            if (s_out != 0) rbad++;
            if (resp_valid) rv++;
            if (init_done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic do_req(input logic [2:0] idx, input bit val,
                          output int lat_k, output bit ok,
                          output int tgt, output int bad,
                          output bit rdy_bad);
        logic [5:0] m;
        logic [5:0] drv;
        logic [5:0] oth;
        lat_k = 0;
        ok = 1'b0;
        tgt = 0;
        bad = 0;
        rdy_bad = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
        if (!req_ready) begin
            rdy_bad = 1'b1;
            return;
        end
        req_idx = idx;
        req_val = val;
        req_valid = 1'b1;
        m = 6'b000001 << idx;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            drv = val ? s_out : r_out;
            oth = val ? r_out : s_out;
            if ((drv & m) != 0) tgt++;
            bad += $countones(drv & ~m) + $countones(oth);
            if (resp_valid) begin
                lat_k = k;
                ok = resp_ok;
                break;
            end
            if (req_ready) rdy_bad = 1'b1;
        end
    endtask

    typedef struct {
        logic [2:0] idx;
        bit         val;
        bit         stuck;
        int         lat;
        bit         ok;
        int         tgt;
        bit         err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int rc, rbad, done_k, rv;
        int lk, tg, bd;
        bit ok, rb;
        int first, rk, second;

        tbl[0] = '{3'd2, 1'b1, 1'b0, 9, 1'b1, 4, 1'b0};
        tbl[1] = '{3'd2, 1'b0, 1'b0, 9, 1'b1, 4, 1'b0};
        tbl[2] = '{3'd0, 1'b1, 1'b0, 9, 1'b1, 4, 1'b0};
        tbl[3] = '{3'd5, 1'b1, 1'b0, 9, 1'b1, 4, 1'b0};
        tbl[4] = '{3'd5, 1'b1, 1'b0, 9, 1'b1, 4, 1'b0};
        tbl[5] = '{3'd7, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0};
        tbl[6] = '{3'd6, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0};
        tbl[7] = '{3'd5, 1'b0, 1'b1, 9, 1'b1, 4, 1'b0};
        tbl[8] = '{3'd5, 1'b1, 1'b1, 25, 1'b0, 12, 1'b1};
        tbl[9] = '{3'd7, 1'b0, 1'b1, 1, 1'b0, 0, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        chk("rst s_out", s_out, 0);
        chk("rst r_out", r_out, 0);
        chk("rst req_ready", req_ready, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst init_done", init_done, 0);
        chk("rst err_sticky", err_sticky, 0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_init(rc, rbad, done_k, rv);
        chk("init r pulse cycles", rc, 4);
        chk("init stray drive", rbad, 0);
        chk("init_done cycle", done_k, 9);
        chk("init resp_valid", rv, 0);
        chk("init err_sticky", err_sticky, 0);
        chk("init req_ready", req_ready, 1);

        for (int i = 0; i < 10; i++) begin
            stuck0 = tbl[i].stuck ? 6'b100000 : 6'b000000;
            do_req(tbl[i].idx, tbl[i].val, lk, ok, tg, bd, rb);
            chk($sformatf("v%0d latency", i), lk, tbl[i].lat);
            chk($sformatf("v%0d resp_ok", i), ok, tbl[i].ok);
            chk($sformatf("v%0d pulse cycles", i), tg, tbl[i].tgt);
            chk($sformatf("v%0d stray drive", i), bd, 0);
            chk($sformatf("v%0d req_ready busy", i), rb, 0);
            chk($sformatf("v%0d err_sticky", i), err_sticky, tbl[i].err);
        end
        stuck0 = '0;

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", err_sticky, 0);

        @(negedge clk);
        req_idx = 3'd1;
        req_val = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("md pulse", s_out, 6'b000010);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("md abort s_out", s_out, 0);
        chk("md abort r_out", r_out, 0);
        chk("md abort resp_valid", resp_valid, 0);
        @(negedge clk);
        chk("md init_done low", init_done, 0);
        rst_n = 1'b1;
        run_init(rc, rbad, done_k, rv);
        chk("md rerun r pulse", rc, 4);
        chk("md rerun stray", rbad, 0);
        chk("md rerun done", done_k, 9);
        chk("md no resp", rv, 0);

        req_idx = 3'd3;
        req_val = 1'b1;
        req_valid = 1'b1;
        first = 0;
        rk = 0;
        second = 0;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (first == 0) begin
                    first = k;
                end else begin
                    second = k;
                    break;
                end
            end
            if (req_ready && rk == 0) rk = k;
        end
        req_valid = 1'b0;
        chk("b2b first resp", first, 9);
        chk("b2b ready again", rk, 10);
        chk("b2b second resp", second, 19);

        @(negedge clk);
        chk("drive overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
